laplace_pio_ctrl: RTL and testbench

Command sequencer between the HPS parallel-I/O pair and the Laplace filter datapath. The HPS writes a 32-bit command word on the PIO output port and reads a 32-bit status word on the PIO input port. The block decodes each command under a four-phase req/ack handshake and drives the pixel frame memory port and the filter engine start/done interface. It sits in the FPGA top level, next to the system interconnect, on the same clock.

---
 rtl/laplace_pkg.sv | 32 +++
 rtl/laplace_pio_ctrl_if.sv | 29 ++
 rtl/laplace_pio_ctrl_lat_counter.sv | 33 +++
 rtl/laplace_pio_ctrl.sv | 141 ++++++++++++++
 tb/tb_laplace_pio_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/laplace_pkg.sv
// Shared constants for the HPS command sequencer: opcodes, PIO field positions
// and the controller FSM state encoding.
package laplace_pkg;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_WRITE  = 3'd1;
    localparam logic [2:0] OP_READ   = 3'd2;
    localparam logic [2:0] OP_RUN    = 3'd3;
    localparam logic [2:0] OP_CLRERR = 3'd4;

    // Command word (pio_out) fields
    localparam int PIO_REQ      = 31;
    localparam int PIO_OP_LO    = 28;
    localparam int PIO_ADDR_LO  = 8;
    localparam int PIO_WDATA_LO = 0;

    // Status word (pio_in) fields
    localparam int ST_ACK      = 31;
    localparam int ST_BUSY     = 30;
    localparam int ST_ERR      = 29;
    localparam int ST_LOP_LO   = 26;
    localparam int ST_RDATA_LO = 0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EXEC  = 3'd1,
        S_RWAIT = 3'd2,
        S_FRUN  = 3'd3,
        S_ACK   = 3'd4
    } state_t;

endpackage

// File: rtl/laplace_pio_ctrl_if.sv
// Bundle of the PIO command/status pair, frame memory port and filter start/done.
// Handshake: the HPS raises req with a stable command; the controller raises ack when
// the command has finished and holds it until req is seen low, then drops ack.
interface laplace_pio_ctrl_if
    import laplace_pkg::*;
#(
    parameter int ADDR_W = 17
);
    logic [31:0]       pio_out;
    logic [31:0]       pio_in;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [7:0]        mem_rdata;
    logic              flt_start;
    logic              flt_done;
    state_t            dbg_state;

    modport master (
        output pio_out, mem_rdata, flt_done,
        input  pio_in, mem_addr, mem_wdata, mem_we, mem_re, flt_start, dbg_state
    );

    modport slave (
        input  pio_out, mem_rdata, flt_done,
        output pio_in, mem_addr, mem_wdata, mem_we, mem_re, flt_start, dbg_state
    );
endinterface

// File: rtl/laplace_pio_ctrl_lat_counter.sv
// Loadable down-counter shared by the read-latency wait and the filter timeout.
// zero is high while the count sits at 0; the count never wraps.
module lat_counter #(
    parameter int W = 21
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/laplace_pio_ctrl.sv
// Command sequencer: decodes HPS PIO commands under req/ack and drives the pixel
// frame memory and the Laplace filter engine.
module laplace_pio_ctrl
    import laplace_pkg::*;
#(
    parameter int ADDR_W   = 17,
    parameter int READ_LAT = 2,
    parameter int TIMEOUT  = 2**20
) (
    input  logic               clk_clk,
    input  logic               reset,
    laplace_pio_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(TIMEOUT + READ_LAT + 1);

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [2:0]        lop_q, lop_d;
    logic [7:0]        rdata_q, rdata_d;

    logic              cnt_load, cnt_en, cnt_zero;
    logic [CNT_W-1:0]  cnt_val;
    logic              we, re, start;
    logic              req;
    logic              unused_bits;

    assign req         = bus.pio_out[PIO_REQ];
    assign unused_bits = ^bus.pio_out[27:25];

    lat_counter #(.W(CNT_W)) u_cnt (
        .clk      (clk_clk),
        .rst      (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (cnt_en),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        lop_d    = lop_q;
        rdata_d  = rdata_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_en   = 1'b0;
        we       = 1'b0;
        re       = 1'b0;
        start    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    op_d    = bus.pio_out[PIO_OP_LO +: 3];
                    addr_d  = bus.pio_out[PIO_ADDR_LO +: ADDR_W];
                    wdata_d = bus.pio_out[PIO_WDATA_LO +: 8];
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_ACK;
                case (op_q)
                    OP_NOP:    state_d = S_ACK;
                    OP_WRITE:  we = 1'b1;
                    OP_READ: begin
                        re       = 1'b1;
                        cnt_load = 1'b1;
                        cnt_val  = CNT_W'(READ_LAT - 1);
                        state_d  = S_RWAIT;
                    end
                    OP_RUN: begin
                        start    = 1'b1;
                        cnt_load = 1'b1;
                        cnt_val  = CNT_W'(TIMEOUT - 1);
                        state_d  = S_FRUN;
                    end
                    OP_CLRERR: err_d = 1'b0;
                    default:   err_d = 1'b1;
                endcase
            end
            S_RWAIT: begin
                cnt_en = 1'b1;
                if (cnt_zero) begin
                    rdata_d = bus.mem_rdata;
                    state_d = S_ACK;
                end
            end
            S_FRUN: begin
                cnt_en = 1'b1;
                // A done arriving on the timeout cycle wins over the timeout.
                if (bus.flt_done) begin
                    state_d = S_ACK;
                end else if (cnt_zero) begin
                    err_d   = 1'b1;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (!req) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if ((state_d == S_ACK) && (state_q != S_ACK)) lop_d = op_q;
    end

    always_ff @(posedge clk_clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            lop_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            lop_q   <= lop_d;
            rdata_q <= rdata_d;
        end
    end

    // Strobes decode straight from registered state so reset drops them at once.
    assign bus.mem_we    = we;
    assign bus.mem_re    = re;
    assign bus.flt_start = start;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.dbg_state = state_q;
    assign bus.pio_in    = {(state_q == S_ACK),
                            (state_q == S_EXEC) || (state_q == S_RWAIT) || (state_q == S_FRUN),
                            err_q, lop_q, 18'b0, rdata_q};
endmodule

// File: tb/tb_laplace_pio_ctrl.sv
// Bench for laplace_pio_ctrl: table of directed commands, hand sequences for the
// multi-cycle corners, and random commands checked against a command-level model.
module tb_laplace_pio_ctrl;
    import laplace_pkg::*;

    localparam int ADDR_W    = 17;
    localparam int READ_LAT  = 2;
    localparam int TIMEOUT_A = 4096;
    localparam int TIMEOUT_B = 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    laplace_pio_ctrl_if #(.ADDR_W(ADDR_W)) bus_a ();
    laplace_pio_ctrl_if #(.ADDR_W(ADDR_W)) bus_b ();

    laplace_pio_ctrl #(.ADDR_W(ADDR_W), .READ_LAT(READ_LAT), .TIMEOUT(TIMEOUT_A)) dut_a (
        .clk_clk (clk), .reset (rst), .bus (bus_a));
    laplace_pio_ctrl #(.ADDR_W(ADDR_W), .READ_LAT(READ_LAT), .TIMEOUT(TIMEOUT_B)) dut_b (
        .clk_clk (clk), .reset (rst), .bus (bus_b));

    // sel picks which instance the driver talks to; the other sees an idle command port
    logic        sel = 1'b0;
    logic [31:0] pio_drv = '0;
    logic        flt_drv = 1'b0;
    logic [31:0] pio_in_v;
    logic        we_v, re_v, st_v;

    assign bus_a.pio_out  = sel ? 32'h0 : pio_drv;
    assign bus_b.pio_out  = sel ? pio_drv : 32'h0;
    assign bus_a.flt_done = sel ? 1'b0 : flt_drv;
    assign bus_b.flt_done = sel ? flt_drv : 1'b0;
    assign bus_b.mem_rdata = 8'h00;
    assign pio_in_v = sel ? bus_b.pio_in : bus_a.pio_in;
    assign we_v     = sel ? bus_b.mem_we : bus_a.mem_we;
    assign re_v     = sel ? bus_b.mem_re : bus_a.mem_re;
    assign st_v     = sel ? bus_b.flt_start : bus_a.flt_start;

    // ---------------- frame memory environment (instance A) ----------------
    logic [7:0]  env_mem [int];
    logic [7:0]  rd_now;
    logic [7:0]  rd_pipe [READ_LAT];
    logic [16:0] last_we_addr = '0;
    logic [7:0]  last_we_data = '0;
    int tot_we = 0, tot_re = 0, tot_st = 0;

    always @(posedge clk) begin
        if (bus_a.mem_we) begin
            env_mem[int'(bus_a.mem_addr)] = bus_a.mem_wdata;
            last_we_addr = bus_a.mem_addr;
            last_we_data = bus_a.mem_wdata;
        end
    end
    assign rd_now = env_mem.exists(int'(bus_a.mem_addr)) ? env_mem[int'(bus_a.mem_addr)] : 8'h00;
    always @(posedge clk) begin
        rd_pipe[0] <= bus_a.mem_re ? rd_now : 8'h00;
        for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus_a.mem_rdata = rd_pipe[READ_LAT-1];

    always @(posedge clk) begin
        if (we_v) tot_we <= tot_we + 1;
        if (re_v) tot_re <= tot_re + 1;
        if (st_v) tot_st <= tot_st + 1;
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q [$];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_status(input logic ack, input logic err,
                                               input logic [2:0] op, input logic [7:0] rd);
        return {ack, 1'b0, err, op, 18'b0, rd};
    endfunction

    // ---------------- reference model ----------------
    logic [7:0] model_mem [int];
    logic       m_err [2];
    logic [7:0] m_rd  [2];
    int exp_lat, exp_we, exp_re, exp_st;

    task automatic model_cmd(input int d, input logic [2:0] op, input logic [16:0] addr,
                             input logic [7:0] wdata, input int dly);
        int tmo;
        tmo = (d == 0) ? TIMEOUT_A : TIMEOUT_B;
        exp_lat = 2; exp_we = 0; exp_re = 0; exp_st = 0;
        case (op)
            3'd1: begin exp_we = 1; if (d == 0) model_mem[int'(addr)] = wdata; end
            3'd2: begin
                exp_re  = 1;
                exp_lat = 2 + READ_LAT;
                m_rd[d] = (d == 0 && model_mem.exists(int'(addr))) ? model_mem[int'(addr)] : 8'h00;
            end
            3'd3: begin
                exp_st = 1;
                if (dly >= 1 && dly <= tmo) exp_lat = dly + 2;
                else begin exp_lat = tmo + 2; m_err[d] = 1'b1; end
            end
            3'd4: m_err[d] = 1'b0;
            3'd5, 3'd6, 3'd7: m_err[d] = 1'b1;
            default: ;
        endcase
    endtask

    // ---------------- driver ----------------
    task automatic issue(input string name, input logic [2:0] op, input logic [16:0] addr,
                         input logic [7:0] wdata, input int dly, input int hold,
                         input int e_lat, input int e_we, input int e_re, input int e_st,
                         input logic e_err, input logic [7:0] e_rd);
        int n, lat, we0, re0, st0;
        logic busy_ok, held_ok;
        logic [31:0] st_ack, st_rel;
        @(negedge clk);
        we0 = tot_we; re0 = tot_re; st0 = tot_st;
        pio_drv = {1'b1, op, 3'b000, addr, wdata};
        n = 0; lat = -1; busy_ok = 1'b1; held_ok = 1'b1; st_ack = '0;
        while (lat < 0 && n < 400) begin
            @(posedge clk); n++;
            @(negedge clk);
            flt_drv = (dly > 0) && (n == 1 + dly);
            // scramble the command word while busy; only the latched copy may matter
            if (n == 1) pio_drv = {1'b1, 3'($urandom_range(0, 7)), 3'b000, 17'($urandom), 8'($urandom)};
            if (pio_in_v[ST_ACK]) begin lat = n; st_ack = pio_in_v; end
            else if (!pio_in_v[ST_BUSY]) busy_ok = 1'b0;
        end
        flt_drv = 1'b0;
        repeat (hold) begin
            @(posedge clk); @(negedge clk);
            if (!pio_in_v[ST_ACK]) held_ok = 1'b0;
        end
        pio_drv = '0;
        @(posedge clk); @(negedge clk);
        st_rel = pio_in_v;
        @(posedge clk); @(negedge clk);
        exp_q.push_back(exp_status(1'b1, e_err, op, e_rd));
        chk({name, "_lat"}, lat, e_lat);
        chk({name, "_busy"}, busy_ok, 1);
        chk({name, "_ack_status"}, st_ack, exp_q.pop_front());
        chk({name, "_strobes"}, (tot_we - we0) * 100 + (tot_re - re0) * 10 + (tot_st - st0),
            e_we * 100 + e_re * 10 + e_st);
        chk({name, "_release"}, st_rel, exp_status(1'b0, e_err, op, e_rd));
        if (e_we != 0) chk({name, "_wr_port"}, {last_we_addr, last_we_data}, {addr, wdata});
        if (hold > 0) chk({name, "_held_ack"}, held_ok, 1);
    endtask

    task automatic run_model(input string name, input int d, input logic [2:0] op,
                             input logic [16:0] addr, input logic [7:0] wdata,
                             input int dly, input int hold);
        model_cmd(d, op, addr, wdata, dly);
        issue(name, op, addr, wdata, dly, hold, exp_lat, exp_we, exp_re, exp_st, m_err[d], m_rd[d]);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [2:0]  op;
        logic [16:0] addr;
        logic [7:0]  wdata;
        int          lat;
        int          n_we;
        int          n_re;
        int          n_st;
        logic        err;
        logic [7:0]  rd;
    } vec_t;

    vec_t tbl [16];
    logic [16:0] pool [4];

    initial begin
        tbl[0]  = '{OP_NOP,    17'h00000, 8'h00, 2,            0, 0, 0, 1'b0, 8'h00};
        tbl[1]  = '{OP_WRITE,  17'h12C40, 8'hA5, 2,            1, 0, 0, 1'b0, 8'h00};
        tbl[2]  = '{OP_READ,   17'h12C40, 8'h00, 2 + READ_LAT, 0, 1, 0, 1'b0, 8'hA5};
        tbl[3]  = '{3'd6,      17'h00055, 8'h11, 2,            0, 0, 0, 1'b1, 8'hA5};
        tbl[4]  = '{OP_NOP,    17'h00000, 8'h00, 2,            0, 0, 0, 1'b1, 8'hA5};
        tbl[5]  = '{OP_CLRERR, 17'h00000, 8'h00, 2,            0, 0, 0, 1'b0, 8'hA5};
        tbl[6]  = '{3'd7,      17'h00001, 8'h22, 2,            0, 0, 0, 1'b1, 8'hA5};
        tbl[7]  = '{OP_CLRERR, 17'h00000, 8'h00, 2,            0, 0, 0, 1'b0, 8'hA5};
        tbl[8]  = '{OP_WRITE,  17'h00001, 8'h3C, 2,            1, 0, 0, 1'b0, 8'hA5};
        tbl[9]  = '{OP_READ,   17'h00001, 8'h00, 2 + READ_LAT, 0, 1, 0, 1'b0, 8'h3C};
        tbl[10] = '{3'd5,      17'h00000, 8'h00, 2,            0, 0, 0, 1'b1, 8'h3C};
        tbl[11] = '{OP_CLRERR, 17'h00000, 8'h00, 2,            0, 0, 0, 1'b0, 8'h3C};
        tbl[12] = '{OP_READ,   17'h12C40, 8'h00, 2 + READ_LAT, 0, 1, 0, 1'b0, 8'hA5};
        tbl[13] = '{OP_READ,   17'h1FFFF, 8'h00, 2 + READ_LAT, 0, 1, 0, 1'b0, 8'h00};
        tbl[14] = '{OP_WRITE,  17'h1FFFF, 8'hFF, 2,            1, 0, 0, 1'b0, 8'h00};
        tbl[15] = '{OP_READ,   17'h1FFFF, 8'h00, 2 + READ_LAT, 0, 1, 0, 1'b0, 8'hFF};
        pool[0] = 17'h12C40; pool[1] = 17'h00001; pool[2] = 17'h1FFFF; pool[3] = 17'h00000;
        m_err[0] = 1'b0; m_err[1] = 1'b0; m_rd[0] = 8'h00; m_rd[1] = 8'h00;

        // reset state
        repeat (3) @(negedge clk);
        chk("reset_pio_a", bus_a.pio_in, 0);
        chk("reset_pio_b", bus_b.pio_in, 0);
        chk("reset_strobes", {bus_a.mem_we, bus_a.mem_re, bus_a.flt_start}, 0);
        chk("reset_mem_port", {bus_a.mem_addr, bus_a.mem_wdata}, 0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            model_cmd(0, tbl[i].op, tbl[i].addr, tbl[i].wdata, 0);
            issue($sformatf("tbl%0d", i), tbl[i].op, tbl[i].addr, tbl[i].wdata, 0, 0,
                  tbl[i].lat, tbl[i].n_we, tbl[i].n_re, tbl[i].n_st, tbl[i].err, tbl[i].rd);
        end

        run_model("held_req", 0, OP_WRITE, 17'h00002, 8'h5A, 0, 20);
        run_model("flt_run", 0, OP_RUN, 17'h00000, 8'h00, 100, 0);

        for (int i = 0; i < 40; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            run_model($sformatf("rnd%0d", i), 0, op, pool[$urandom_range(0, 3)], 8'($urandom),
                      (op == OP_RUN) ? $urandom_range(1, 40) : 0, $urandom_range(0, 3));
        end

        // reset while a read is waiting on memory latency
        @(negedge clk);
        pio_drv = {1'b1, OP_READ, 3'b000, 17'h12C40, 8'h00};
        @(posedge clk); @(negedge clk);
        chk("mr_re_before", bus_a.mem_re, 1);
        @(posedge clk); @(negedge clk);
        chk("mr_busy_before", bus_a.pio_in[ST_BUSY], 1);
        #1 rst = 1'b1;
        #1;
        chk("mr_pio", bus_a.pio_in, 0);
        chk("mr_re", bus_a.mem_re, 0);
        chk("mr_addr", bus_a.mem_addr, 0);
        pio_drv = '0;
        @(negedge clk);
        rst = 1'b0;
        m_err[0] = 1'b0; m_err[1] = 1'b0; m_rd[0] = 8'h00; m_rd[1] = 8'h00;
        run_model("after_reset_read", 0, OP_READ, 17'h12C40, 8'h00, 0, 0);

        // short-timeout instance
        sel = 1'b1;
        run_model("to_boundary", 1, OP_RUN, 17'h00000, 8'h00, TIMEOUT_B, 0);
        run_model("to_withheld", 1, OP_RUN, 17'h00000, 8'h00, 0, 0);
        run_model("to_nop", 1, OP_NOP, 17'h00000, 8'h00, 0, 0);
        run_model("to_clrerr", 1, OP_CLRERR, 17'h00000, 8'h00, 0, 0);
        sel = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
